// File: rtl/expr_checker.sv
// expr_checker: streaming syntax checker for infix arithmetic expressions.
// One ASCII character is consumed per cycle with in_valid high; out flags a
// complete well-formed prefix, err is a sticky syntax error.
// Optional feature macro: EXPR_PAREN_EN enables parenthesis nesting and depth.
module expr_checker #(
  parameter int MAX_DEPTH   = 4,
  parameter int MULTI_DIGIT = 1,
  parameter int OPS_EXT     = 0,
  parameter int CNT_W       = 8,
  parameter int DEPTH_W     = $clog2(MAX_DEPTH+1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   opnd_cnt
);

  typedef enum logic [2:0] {S_START, S_OP, S_NUM, S_CLOSE, S_ERR} state_t;

  state_t     state, nxt;
  logic       is_dig, is_op, is_lp, is_rp;
  logic       at_max, at_zero;
  logic       dep_inc, dep_dec, cnt_inc;
  logic [CNT_W-1:0] cnt_q;

  assign is_dig = (in >= 8'h30) && (in <= 8'h39);
  assign is_op  = (in == 8'h2B) || (in == 8'h2A) ||
                  ((OPS_EXT != 0) && ((in == 8'h2D) || (in == 8'h2F)));

`ifdef EXPR_PAREN_EN
  logic [DEPTH_W-1:0] depth_q;

  assign is_lp   = (in == 8'h28);
  assign is_rp   = (in == 8'h29);
  assign at_max  = (depth_q == DEPTH_W'(MAX_DEPTH));
  assign at_zero = (depth_q == '0);

  // Nesting depth; only legal transitions move it, so it freezes on error.
  always_ff @(posedge clk) begin
    if (clr)
      depth_q <= '0;
    else if (in_valid) begin
      if (dep_inc)      depth_q <= depth_q + DEPTH_W'(1);
      else if (dep_dec) depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  assign depth = depth_q;
`else
  // Parentheses fall into the illegal class; no depth state exists.
  logic unused_paren;

  assign is_lp        = 1'b0;
  assign is_rp        = 1'b0;
  assign at_max       = 1'b1;
  assign at_zero      = 1'b1;
  assign unused_paren = dep_inc ^ dep_dec;
  assign depth        = '0;
`endif

  // Next-state decode; anything not explicitly legal lands in S_ERR.
  always_comb begin
    nxt     = state;
    dep_inc = 1'b0;
    dep_dec = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      S_START, S_OP: begin
        if (is_dig) begin
          nxt     = S_NUM;
          cnt_inc = 1'b1;
        end else if (is_lp && !at_max) begin
          nxt     = S_OP;
          dep_inc = 1'b1;
        end else
          nxt = S_ERR;
      end
      S_NUM: begin
        if (is_dig)
          nxt = (MULTI_DIGIT != 0) ? S_NUM : S_ERR;
        else if (is_op)
          nxt = S_OP;
        else if (is_rp && !at_zero) begin
          nxt     = S_CLOSE;
          dep_dec = 1'b1;
        end else
          nxt = S_ERR;
      end
      S_CLOSE: begin
        if (is_op)
          nxt = S_OP;
        else if (is_rp && !at_zero) begin
          nxt     = S_CLOSE;
          dep_dec = 1'b1;
        end else
          nxt = S_ERR;
      end
      default: nxt = S_ERR;
    endcase
  end

  // State register; clr wins over everything, in_valid low holds.
  always_ff @(posedge clk) begin
    if (clr)
      state <= S_START;
    else if (in_valid)
      state <= nxt;
  end

  // Operand counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (clr)
      cnt_q <= '0;
    else if (in_valid && cnt_inc && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign opnd_cnt = cnt_q;
  assign out      = ((state == S_NUM) || (state == S_CLOSE)) && at_zero;
  assign err      = (state == S_ERR);

endmodule

// File: doc/expr_checker.md
# expr_checker

Streaming syntax checker for infix arithmetic expressions, one ASCII character per accepted cycle. It generalises the fixed single-digit `+`/`*` expression FSM with several additions:
- an input-valid qualifier;
- multi-digit operands and an optional extended operator set;
- bounded parenthesis nesting;
- a sticky error flag and an operand counter.

It sits behind the character-input path and tells downstream logic whether the prefix received so far is a complete, well-formed expression.

## Interface
- `MAX_DEPTH`, 4: maximum parenthesis nesting depth, ≥1.
- `MULTI_DIGIT`, 1: 1 = operands may be several digits; 0 = an operand is exactly one digit.
- `OPS_EXT`, 0: 0 = operators are `+` and `*` only; 1 = `-` and `/` are also accepted.
- `CNT_W`, 8: width of the operand counter.
- `DEPTH_W`, `$clog2(MAX_DEPTH+1)`: width of the depth output (derived parameter).

Ports:
- `clk`  in  1  clock. One clock; all state updates on the rising edge.
- `clr`  in  1  synchronous, active-high reset. It has priority over every other input.
- `in_valid`  in  1  `in` is sampled only when this is high.
- `in`  in  8  ASCII character.
- `out`  out  1  high when the accepted prefix is a complete, legal expression.
- `err`  out  1  sticky syntax-error flag.
- `depth`  out  DEPTH_W  current open-parenthesis count.
- `opnd_cnt`  out  CNT_W  number of operands started; saturates.

## Operation
Character classes:
- DIG: `0`–`9`.
- OP: `+`, `*`, plus `-` and `/` when `OPS_EXT=1`.
- LP: `(`.
- RP: `)`.
- Everything else is ILL.

States are S_START, S_OP, S_NUM, S_CLOSE and S_ERR. Transitions apply only on `clk` when `in_valid=1` and `clr=0`.

- S_START / S_OP:
  - DIG → S_NUM, `opnd_cnt`+1.
  - LP → if `depth==MAX_DEPTH` then S_ERR, else `depth`+1 and go to S_OP.
  - OP, RP, ILL → S_ERR.
- S_NUM:
  - DIG → stay in S_NUM if `MULTI_DIGIT=1` (counter unchanged), else S_ERR.
  - OP → S_OP.
  - RP → if `depth==0` then S_ERR, else `depth`−1 and go to S_CLOSE.
  - LP, ILL → S_ERR.
- S_CLOSE:
  - OP → S_OP.
  - RP → same rule as RP in S_NUM.
  - DIG, LP, ILL → S_ERR.
- S_ERR: absorbing. Only `clr` leaves it.

Outputs:
- `out = (state∈{S_NUM,S_CLOSE}) && depth==0`. This is Moore decoding from registered state.
- `err = (state==S_ERR)`.
- On entry to S_ERR, `depth` and `opnd_cnt` freeze at their values before the offending character.
- `opnd_cnt` saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Reset: `clr=1` at an edge forces S_START, `depth=0`, `opnd_cnt=0`, `out=0` and `err=0` on that edge. This holds regardless of `in_valid` or the current state, including mid-expression and in S_ERR.
- Latency: a character sampled at edge N is reflected on `out`, `err`, `depth` and `opnd_cnt` immediately after edge N, i.e. valid during cycle N+1. There is no combinational path from `in` to any output.
- `in_valid=0` at an edge: all state and outputs hold. Back-to-back valid characters are accepted every cycle with no stall.
- Simultaneous events:
  - LP at `depth==MAX_DEPTH` produces an error, not saturation.
  - RP at `depth==0` produces an error, not underflow.
  - A DIG that would overflow `opnd_cnt` is still legal; the counter stays at its maximum.

## Configuration
- `EXPR_PAREN_EN` defined: parenthesis handling as specified above, and `depth` is live.
- Not defined: LP and RP are classified ILL (→ S_ERR), `depth` is tied to 0, and `MAX_DEPTH` is ignored. The parenthesis logic and depth register are not synthesised.

## Test plan
- Reset, then `1`,`+`,`1`,`*`,`0` on consecutive cycles. Required: `out` = 1,0,1,0,1 after each character; `err`=0; `opnd_cnt`=3.
- `MULTI_DIGIT=0`, input `1`,`1`. Required: `out`=1 after the first `1`; after the second, `err`=1 and `out`=0. Repeat with `MULTI_DIGIT=1`: `out`=1 throughout and `opnd_cnt`=1.
- `EXPR_PAREN_EN`, input `(`,`1`,`+`,`2`,`)`,`*`,`3`.
  - `depth` = 1,1,1,1,0,0,0.
  - `out` = 0,0,0,0,1,0,1.
  - An extra `)` then gives `err`=1 with `depth` held at 0.
- `EXPR_PAREN_EN`, `MAX_DEPTH=2`, input `(`,`(`,`(`. Required: `depth` = 1,2; `err`=1 after the third character, with `depth` frozen at 2. Further valid `1`s leave `err`=1 and `out`=0.
- `OPS_EXT=0`, input `9`,`-`,`1`: `err`=1 after `-`. With `OPS_EXT=1`: `out` = 1,0,1 and `err`=0.
- Input `1`,`+` with `in_valid` toggling 1,0,1. Required: outputs hold during the gap. Then assert `clr` together with `in_valid=1` and `in`=`5`: next cycle S_START, `out`=0, `err`=0, `opnd_cnt`=0, and the `5` is ignored.
